// File: rtl/mac_acc_seq_if.sv
// Stream, MAC-bus and result signals between mac_acc_seq and its
// neighbours. The slave modport is the sequencer; master is the environment.
interface mac_acc_seq_if #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int len_bw  = 8
);
   logic               start;
   logic [len_bw-1:0]  len;
   logic               relu_en;
   logic               in_valid;
   logic               in_ready;
   logic [bw-1:0]      in_a;
   logic [bw-1:0]      in_b;
   logic [bw-1:0]      mac_a;
   logic [bw-1:0]      mac_b;
   logic [psum_bw-1:0] mac_c;
   logic [psum_bw-1:0] mac_out;
   logic               out_valid;
   logic               out_ready;
   logic [psum_bw-1:0] out_data;
   logic               busy;

   modport master (
      output start, len, relu_en, in_valid, in_a, in_b,
      output mac_out, out_ready,
      input  in_ready, mac_a, mac_b, mac_c,
      input  out_valid, out_data, busy
   );

   modport slave (
      input  start, len, relu_en, in_valid, in_a, in_b,
      input  mac_out, out_ready,
      output in_ready, mac_a, mac_b, mac_c,
      output out_valid, out_data, busy
   );
endinterface

// File: rtl/mac_acc_seq.sv
// Dot-product sequencer: feeds pairs to an external MAC, loops the
// running psum back through mac_c and returns the (optionally ReLU'd) sum.
module mac_acc_seq #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int len_bw  = 8,
   parameter int MAC_LAT = 2
) (
   input logic          clk,
   input logic          reset,
   mac_acc_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam int WW = 3;

   state_t             state_q, state_d;
   logic [psum_bw-1:0] psum_q, psum_d;
   logic [len_bw-1:0]  cnt_q, cnt_d;
   logic [len_bw-1:0]  len_q, len_d;
   logic               relu_q, relu_d;
   logic [WW-1:0]      wait_q, wait_d;
   logic [bw-1:0]      mac_a_q, mac_a_d;
   logic [bw-1:0]      mac_b_q, mac_b_d;
   logic [psum_bw-1:0] mac_c_q, mac_c_d;
   logic [psum_bw-1:0] out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic [len_bw-1:0]  cnt_inc;

   assign cnt_inc = cnt_q + len_bw'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         psum_q      <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         relu_q      <= 1'b0;
         wait_q      <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_c_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         psum_q      <= psum_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         relu_q      <= relu_d;
         wait_q      <= wait_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_c_q     <= mac_c_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      psum_d      = psum_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      relu_d      = relu_q;
      wait_d      = wait_q;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      mac_c_d     = mac_c_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d   = bus.len;
               relu_d  = bus.relu_en;
               psum_d  = '0;
               cnt_d   = '0;
               state_d = (bus.len == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (bus.in_valid) begin
               mac_a_d = bus.in_a;
               mac_b_d = bus.in_b;
               mac_c_d = psum_q;
               wait_d  = WW'(MAC_LAT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            wait_d = wait_q - WW'(1);
            // Last latency edge: the MAC result for the held operands is valid
            if (wait_q == WW'(1)) begin
               psum_d  = bus.mac_out;
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == len_q) ? DONE : ISSUE;
            end
         end
         DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = (relu_q && psum_q[psum_bw-1]) ? '0 : psum_q;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == ISSUE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.mac_a     = mac_a_q;
   assign bus.mac_b     = mac_b_q;
   assign bus.mac_c     = mac_c_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: doc/mac_acc_seq.md
Name: mac_acc_seq

Overview:
- Sequencer and accumulator that wraps one mac_wrapper instance and runs a full dot product of length len.
- Accepts (activation, weight) pairs over a valid/ready stream and drives mac_wrapper a/b/c.
- Feeds the running partial sum back as c and captures the MAC result.
- Delivers the final (optionally ReLU'd) psum downstream with a valid/ready handshake.

Parameters:
- bw, 4: activation/weight width; activation unsigned, weight two's complement.
- psum_bw, 16: partial-sum width, two's complement.
- len_bw, 8: width of the len input.
- MAC_LAT, 2: rising edges from a mac_a/mac_b/mac_c update until mac_out is valid to sample; legal range 1..4.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin a new dot product; honoured only in IDLE.
- len  in  len_bw  number of pairs; sampled with start.
- relu_en  in  1  clamp negative results to 0; sampled with start.
- in_valid  in  1  in_a/in_b valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_a  in  bw  activation (unsigned).
- in_b  in  bw  weight (signed).
- mac_a  out  bw  to mac_wrapper a.
- mac_b  out  bw  to mac_wrapper b.
- mac_c  out  psum_bw  to mac_wrapper c (running psum).
- mac_out  in  psum_bw  from mac_wrapper out.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  psum_bw  final result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; psum=0, cnt=0, wait_cnt=0, len_q=0, relu_q=0. Outputs: mac_a=0, mac_b=0, mac_c=0, out_data=0, out_valid=0, busy=0; in_ready=0 (combinational from state). Any in-flight MAC result is discarded; reset mid-operation is a legal, full abort.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=0.
  - On start=1, latch len_q=len and relu_q=relu_en; clear psum and cnt.
  - If len==0, go to DONE with out_data=0. Otherwise go to ISSUE.
- ISSUE:
  - in_ready=1, combinational: in_ready = (state==ISSUE).
  - On in_valid&&in_ready: mac_a<=in_a, mac_b<=in_b, mac_c<=psum, wait_cnt<=MAC_LAT, then go to WAIT.
  - in_valid low means stay in ISSUE indefinitely.
- WAIT:
  - in_ready=0; decrement wait_cnt each edge.
  - On the edge where wait_cnt==1 (the MAC_LAT-th edge after the load): psum<=mac_out, cnt<=cnt+1.
  - If cnt+1==len_q, go to DONE. Otherwise go to ISSUE.
  - mac_a/b/c hold stable throughout WAIT.
- DONE:
  - On entry, out_data <= (relu_q && psum[psum_bw-1]) ? 0 : psum; out_valid=1.
  - out_data and out_valid hold until out_valid&&out_ready, which returns to IDLE with out_valid=0 on that edge. out_data keeps its last value.
- Throughput: one pair per MAC_LAT+1 cycles at best.
- Latency from start edge to out_valid: len*(MAC_LAT+1)+1 edges with in_valid held high.
- Arithmetic:
  - The block performs no multiply; psum is exactly mac_out.
  - Overflow wraps modulo 2^psum_bw with no saturation.
  - in_a/in_b pass through unchanged.
- start outside IDLE is ignored. start and out_ready both high in DONE: the handshake completes and the start is ignored.
- len==2^len_bw-1 is legal; cnt is len_bw bits.
- in_valid asserted outside ISSUE: no pair consumed.

Test Plan:
- MAC_LAT=2, len=10, relu_en=0; stream (a,b) = (6,1),(7,-7),(1,7),(3,-4),(2,-3),(2,-2),(15,-4),(4,5),(6,-6),(4,4) with in_valid held high -> mac_c sequence 0000,0006,FFD5,FFDC,FFD0,FFCA,FFC6,FF8A,FF9E,FF7A; out_data=16'hFF8A; out_valid high 31 edges after the start edge.
- Same stream with relu_en=1 -> out_data=16'h0000. Then len=1, (3,2), relu_en=1 -> out_data=16'h0006.
- len=0 with start -> DONE on the next edge, out_data=0, in_ready never asserted.
- Backpressure and gaps:
  - in_valid low 3 cycles between pairs -> no pair lost, same final result.
  - out_ready low 5 cycles in DONE -> out_valid and out_data stable, busy=1; single accept edge returns to IDLE.
- Drive reset low for 1 cycle during WAIT of pair 4 -> all outputs 0 immediately. A new start with len=2, (1,1),(1,1) -> out_data=16'h0002, with no residue from the aborted run.
- start pulsed during ISSUE/WAIT/DONE -> ignored, len_q unchanged, result unaffected. Repeat the first scenario at MAC_LAT=1 -> same out_data, out_valid after 21 edges.
